// File: rtl/simon_key_expand.sv
// Simon key schedule: latches an M*N-bit master key, streams k[0..T-1] one per cycle and keeps them in a
// T-entry register array with a registered read port. Define SIMON_KEYX_ZEROIZE_EN to add the zeroize input.
module simon_key_expand #(
  parameter int N  = 64,
  parameter int M  = 4,
  parameter int T  = 72,
  parameter int j  = 4,
  parameter int AW = $clog2(T)
) (
  input  logic           clk,
  input  logic           rst,
`ifdef SIMON_KEYX_ZEROIZE_EN
  input  logic           zeroize,
`endif
  input  logic           start,
  input  logic [M*N-1:0] key,
  output logic           busy,
  output logic           done,
  output logic           keys_ready,
  output logic           rk_valid,
  output logic [AW-1:0]  rk_idx,
  output logic [N-1:0]   rk,
  input  logic [AW-1:0]  rd_addr,
  output logic [N-1:0]   rd_key
);

  // Leftmost character of each sequence is bit 0, i.e. bit 61 of the literal.
  localparam logic [61:0] ZSEQ =
    (j == 0) ? 62'b11111010001001010110000111001101111101000100101011000011100110 :
    (j == 1) ? 62'b10001110111110010011000010110101000111011111001001100001011010 :
    (j == 2) ? 62'b10101111011100000011010010011000101000010001111110010110110011 :
    (j == 3) ? 62'b11011011101011000110010111100000010010001010011100110100001111 :
               62'b11010001111001101011011000100000010111000011001010010011101111;

  typedef enum logic [1:0] {IDLE, LOAD, GEN, FIN} state_t;

  state_t         state, state_nx;
  logic [AW-1:0]  idx;
  logic [5:0]     zc;
  logic [N-1:0]   win [M];
  logic [N-1:0]   ks  [T];
  logic [N-1:0]   tmp;
  logic [N-1:0]   k_new;
  logic [N-1:0]   word_in;
  logic           wipe;

  function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int r);
    return (x >> r) | (x << (N - r));
  endfunction

`ifdef SIMON_KEYX_ZEROIZE_EN
  assign wipe = rst | zeroize;
`else
  assign wipe = rst;
`endif

  // win[0] is k[i-M], win[M-1] is k[i-1]; the z bit lands in bit 0 only.
  always_comb begin
    tmp = ror(win[M-1], 3);
    if (M == 4) tmp = tmp ^ win[1];
    tmp     = tmp ^ ror(tmp, 1);
    k_new   = ~win[0] ^ tmp ^ {{(N-1){1'b0}}, ZSEQ[6'd61 - zc]} ^ N'(3);
    // LOAD rotates the window so it is back in key order when GEN starts.
    word_in = (state == LOAD) ? win[0] : k_new;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if (idx == AW'(M - 1)) state_nx = GEN;
      GEN:     if (idx == AW'(T - 1)) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wipe) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_ready <= 1'b0;
      rk_valid   <= 1'b0;
      rk_idx     <= '0;
      rk         <= '0;
      rd_key     <= '0;
      idx        <= '0;
      zc         <= '0;
      for (int w = 0; w < M; w++) win[w] <= '0;
      for (int a = 0; a < T; a++) ks[a] <= '0;
    end else begin
      state  <= state_nx;
      done   <= 1'b0;
      rd_key <= (int'(rd_addr) < T) ? ks[rd_addr] : '0;
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int w = 0; w < M; w++) win[w] <= key[w*N +: N];
            busy       <= 1'b1;
            keys_ready <= 1'b0;
            idx        <= '0;
            zc         <= '0;
          end
        end
        LOAD, GEN: begin
          rk_valid <= 1'b1;
          rk_idx   <= idx;
          rk       <= word_in;
          ks[idx]  <= word_in;
          for (int w = 0; w < M - 1; w++) win[w] <= win[w+1];
          win[M-1] <= word_in;
          idx      <= idx + AW'(1);
          if (state == GEN) zc <= (zc == 6'd61) ? 6'd0 : zc + 6'd1;
          if (state == GEN && idx == AW'(T - 1)) busy <= 1'b0;
        end
        FIN: begin
          done       <= 1'b1;
          keys_ready <= 1'b1;
          rk_valid   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_key_expand.sv
// Randomized self-checking bench for simon_key_expand: a 128-bit-block instance (N=64,M=4,T=72,j=4)
// and a Simon32/64 instance (N=16,M=4,T=32,j=0), both checked against a key-schedule reference model.
module tb_simon_key_expand;
  localparam int T64 = 72;
  localparam int T16 = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          st64, busy64, done64, kr64, rv64;
  logic [255:0]  key64;
  logic [6:0]    ridx64, rda64;
  logic [63:0]   rk64, rdk64;
  logic          st16, busy16, done16, kr16, rv16;
  logic [63:0]   key16;
  logic [4:0]    ridx16, rda16;
  logic [15:0]   rk16, rdk16;
`ifdef SIMON_KEYX_ZEROIZE_EN
  logic          zeroize;
`endif

  simon_key_expand #(.N(64), .M(4), .T(T64), .j(4)) dut64 (
    .clk(clk), .rst(rst),
`ifdef SIMON_KEYX_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .start(st64), .key(key64), .busy(busy64), .done(done64), .keys_ready(kr64),
    .rk_valid(rv64), .rk_idx(ridx64), .rk(rk64), .rd_addr(rda64), .rd_key(rdk64)
  );

  simon_key_expand #(.N(16), .M(4), .T(T16), .j(0)) dut16 (
    .clk(clk), .rst(rst),
`ifdef SIMON_KEYX_ZEROIZE_EN
    .zeroize(1'b0),
`endif
    .start(st16), .key(key16), .busy(busy16), .done(done16), .keys_ready(kr16),
    .rk_valid(rv16), .rk_idx(ridx16), .rk(rk16), .rd_addr(rda16), .rd_key(rdk16)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  string       zs [0:4];
  logic [63:0] mk    [0:71];
  logic [63:0] exp64 [0:71];
  logic [63:0] got64 [0:71];
  logic [15:0] got16 [0:31];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int r, input int n);
    logic [63:0] mask;
    mask = (n == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << n) - 64'd1);
    return ((x >> r) | (x << (n - r))) & mask;
  endfunction

  // Reference schedule: k[i] = c ^ z_j[(i-m) mod 62] ^ k[i-m] ^ (I ^ S^-1)(S^-3 k[i-1] ^ k[i-3]), c = 2^n - 4.
  task automatic model_keys(input int n, input int m, input int t, input int jj, input logic [255:0] k);
    logic [63:0] mask, c, tmp, zb;
    mask = (n == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << n) - 64'd1);
    c    = mask ^ 64'd3;
    for (int i = 0; i < m; i++) mk[i] = 64'(k >> (i * n)) & mask;
    for (int i = m; i < t; i++) begin
      tmp = rotr(mk[i-1], 3, n);
      if (m == 4) tmp = tmp ^ mk[i-3];
      tmp = tmp ^ rotr(tmp, 1, n);
      zb  = (zs[jj][(i - m) % 62] == 8'd49) ? 64'd1 : 64'd0;
      mk[i] = c ^ zb ^ mk[i-m] ^ tmp;
    end
  endtask

  function automatic logic [15:0] rol16(input logic [15:0] x, input int r);
    return (x << r) | (x >> (16 - r));
  endfunction

  function automatic logic [31:0] enc16(input logic [31:0] pt);
    logic [15:0] x, y, t;
    x = pt[31:16];
    y = pt[15:0];
    for (int r = 0; r < T16; r++) begin
      t = x;
      x = y ^ (rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2) ^ got16[r];
      y = t;
    end
    return {x, y};
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // dist_at: edge (relative to the accepting edge c) at which a stray start is sampled; rst_at likewise for rst.
  task automatic expand64(input logic [255:0] k, input int dist_at, input int rst_at);
    int busy_n, done_n, done_t;
    done_n = 0;
    done_t = -1;
    model_keys(64, 4, T64, 4, k);
    for (int i = 0; i < T64; i++) exp64[i] = mk[i];
    @(negedge clk);
    st64  = 1'b1;
    key64 = k;
    @(negedge clk);
    st64  = 1'b0;
    key64 = ~k;
    chk("busy_on", busy64, 1);
    chk("kr_drop", kr64, 0);
    busy_n = 1;
    for (int t = 1; t <= T64 + 3; t++) begin
      @(negedge clk);
      if (rst_at != 0 && t >= rst_at) begin
        if (t == rst_at) begin
          chk("rst_busy", busy64, 0);
          chk("rst_rv", rv64, 0);
          chk("rst_kr", kr64, 0);
          chk("rst_rk", rk64, 0);
        end
        if (done64) done_n++;
      end else begin
        if (busy64) busy_n++;
        if (done64) begin
          done_n++;
          done_t = t;
        end
        if (t <= T64) begin
          chk("rv64", rv64, 1);
          chk("idx64", ridx64, 64'(t - 1));
          chk("rk64", rk64, exp64[t-1]);
          got64[t-1] = rk64;
        end else if (t == T64 + 1) begin
          chk("rv64_off", rv64, 0);
          chk("kr64_set", kr64, 1);
          chk("busy64_off", busy64, 0);
        end
      end
      st64 = (t + 1 == dist_at);
      if (st64) key64 = rand256();
      rst  = (t + 1 == rst_at);
    end
    st64 = 1'b0;
    rst  = 1'b0;
    if (rst_at == 0) begin
      chk("busy_cycles", 64'(busy_n), 64'(T64));
      chk("done_count", 64'(done_n), 64'd1);
      chk("done_time", 64'(done_t), 64'(T64 + 1));
    end else begin
      chk("rst_no_done", 64'(done_n), 64'd0);
    end
  endtask

  task automatic expand16(input logic [63:0] k);
    int busy_n, done_n;
    done_n = 0;
    model_keys(16, 4, T16, 0, {192'd0, k});
    @(negedge clk);
    st16  = 1'b1;
    key16 = k;
    @(negedge clk);
    st16   = 1'b0;
    key16  = ~k;
    busy_n = int'(busy16);
    for (int t = 1; t <= T16 + 2; t++) begin
      @(negedge clk);
      if (busy16) busy_n++;
      if (done16) begin
        done_n++;
        chk("done16_time", 64'(t), 64'(T16 + 1));
      end
      if (t <= T16) begin
        chk("rv16", rv16, 1);
        chk("idx16", ridx16, 64'(t - 1));
        chk("rk16", rk16, mk[t-1] & 64'hffff);
        got16[t-1] = rk16;
      end
    end
    chk("busy16_cycles", 64'(busy_n), 64'(T16));
    chk("done16_count", 64'(done_n), 64'd1);
    chk("kr16", kr16, 1);
  endtask

  task automatic rd_sweep64();
    for (int a = T64 - 1; a >= 0; a--) begin
      rda64 = 7'(a);
      @(negedge clk);
      chk("rd_key", rdk64, exp64[a]);
    end
    for (int a = T64; a < 128; a++) begin
      rda64 = 7'(a);
      @(negedge clk);
      chk("rd_oob", rdk64, 64'd0);
    end
    for (int r = 0; r < 16; r++) begin
      rda64 = 7'($urandom_range(T64 - 1, 0));
      @(negedge clk);
      chk("rd_rand", rdk64, exp64[rda64]);
    end
  endtask

  initial begin
    zs[0] = "11111010001001010110000111001101111101000100101011000011100110";
    zs[1] = "10001110111110010011000010110101000111011111001001100001011010";
    zs[2] = "10101111011100000011010010011000101000010001111110010110110011";
    zs[3] = "11011011101011000110010111100000010010001010011100110100001111";
    zs[4] = "11010001111001101011011000100000010111000011001010010011101111";
    rst   = 1'b1;
    st64  = 1'b0;
    st16  = 1'b0;
    key64 = '0;
    key16 = '0;
    rda64 = '0;
    rda16 = '0;
`ifdef SIMON_KEYX_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy64", busy64, 0);
    chk("rst_done64", done64, 0);
    chk("rst_kr64", kr64, 0);
    chk("rst_rv64", rv64, 0);
    chk("rst_idx64", ridx64, 0);
    chk("rst_rk64", rk64, 0);
    chk("rst_rdkey64", rdk64, 0);
    chk("rst_busy16", busy16, 0);
    chk("rst_kr16", kr16, 0);
    rst = 1'b0;

    // Reference key, then the streamed words 0..3 against the literal key words.
    expand64(256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100, 0, 0);
    chk("k64_0", got64[0], 64'h0706050403020100);
    chk("k64_1", got64[1], 64'h0f0e0d0c0b0a0908);
    chk("k64_2", got64[2], 64'h1716151413121110);
    chk("k64_3", got64[3], 64'h1f1e1d1c1b1a1918);
    rd_sweep64();

    // Simon32/64 known answer through the 16-bit instance.
    expand16(64'h1918111009080100);
    chk("k16_0", got16[0], 64'h0100);
    chk("k16_1", got16[1], 64'h0908);
    chk("k16_2", got16[2], 64'h1110);
    chk("k16_3", got16[3], 64'h1918);
    chk("enc16_kat", enc16(32'h65656877), 32'hc69be9bb);

    // Stray start during expansion, then check the array is untouched by it.
    expand64(rand256(), 10, 0);
    rd_sweep64();

    // Reset mid-expansion, then a clean run.
    expand64(rand256(), 0, 30);
    expand64(rand256(), 0, 0);
    rd_sweep64();

    for (int r = 0; r < 4; r++) expand64(rand256(), 0, 0);
    for (int r = 0; r < 4; r++) expand16({$urandom, $urandom});

`ifdef SIMON_KEYX_ZEROIZE_EN
    @(negedge clk);
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    chk("zz_kr", kr64, 0);
    chk("zz_busy", busy64, 0);
    chk("zz_rv", rv64, 0);
    for (int a = 0; a < 128; a++) begin
      rda64 = 7'(a);
      @(negedge clk);
      chk("zz_rd", rdk64, 64'd0);
    end
    expand64(rand256(), 0, 0);
    rd_sweep64();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
